window3x3_gen: RTL and testbench



---
 rtl/window3x3_gen_if.sv | 14 +
 rtl/window3x3_gen.sv | 92 +++++++++
 tb/tb_window3x3_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/window3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for window3x3_gen.
// slave is the window generator side, master is the stream source / window consumer.
interface window3x3_gen_if #(
    parameter int WIDTH = 8
);
    logic                 ivalid;
    logic [WIDTH-1:0]     pixel_in;
    logic                 ovalid;
    logic [9*WIDTH-1:0]   win_out;
    logic                 frame_done;

    modport master (output ivalid, pixel_in, input ovalid, win_out, frame_done);
    modport slave  (input ivalid, pixel_in, output ovalid, win_out, frame_done);
endinterface

// File: rtl/window3x3_gen.sv
// Raster-scan 3x3 window generator with two internal line delays.
// Emits a registered window only where the full neighbourhood lies inside the frame.
module window3x3_gen #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic              clock,
    input  logic              reset,
    window3x3_gen_if.slave    bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept, col_last, row_last, fire;

    logic [WIDTH-1:0] lb1 [IMG_W];
    logic [WIDTH-1:0] lb2 [IMG_W];
    logic [WIDTH-1:0] lb1_rd, lb2_rd;

    // tap[r][k]: r=0 top (row-2), k=2 newest column
    logic [2:0][2:0][WIDTH-1:0] tap, nxt_tap;
    logic [2:0][WIDTH-1:0]      col_in;

    assign accept   = bus.ivalid;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign fire     = accept && (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Read-before-write: the old lb1 entry cascades into lb2 on the same edge
    assign lb1_rd = lb1[col];
    assign lb2_rd = lb2[col];

    always_ff @(posedge clock) begin
        if (accept) begin
            lb1[col] <= bus.pixel_in;
            lb2[col] <= lb1_rd;
        end
    end

    assign col_in[0] = lb2_rd;
    assign col_in[1] = lb1_rd;
    assign col_in[2] = bus.pixel_in;

    always_comb begin
        nxt_tap = tap;
        for (int r = 0; r < 3; r++) begin
            nxt_tap[r] = {col_in[r], tap[r][2:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tap <= '0;
        end else if (accept) begin
            tap <= nxt_tap;
        end
    end

    // Window is captured from the post-shift taps so it lines up with ovalid
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.ovalid     <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.win_out    <= '0;
        end else begin
            bus.ovalid     <= fire;
            bus.frame_done <= fire && row_last && col_last;
            if (fire) begin
                bus.win_out <= nxt_tap;
            end
        end
    end
endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: frame-store model compared every cycle, plus literal window checks.
module tb_window3x3_gen;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic clock;
    logic reset;

    window3x3_gen_if #(.WIDTH(PW)) bus ();

    window3x3_gen #(.WIDTH(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert;
    int n_fail;

    // Model: remember every accepted pixel of the frame at its (row, col)
    logic [PW-1:0] img [H][W];
    int            mr, mc;
    logic          exp_v, exp_fd;
    logic [71:0]   exp_win;

    function automatic logic [71:0] win_at(input int r, input int c, input logic [PW-1:0] p);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*8 +: 8] = (i == 2 && j == 2) ? p : img[r-2+i][c-2+j];
        return w;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            mr <= 0; mc <= 0;
            exp_v <= 1'b0; exp_fd <= 1'b0; exp_win <= '0;
        end else if (bus.ivalid) begin
            img[mr][mc] <= bus.pixel_in;
            exp_v  <= (mr >= 2 && mc >= 2);
            exp_fd <= (mr == H-1 && mc == W-1);
            if (mr >= 2 && mc >= 2) exp_win <= win_at(mr, mc, bus.pixel_in);
            if (mc == W-1) begin
                mc <= 0;
                mr <= (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc <= mc + 1;
            end
        end else begin
            exp_v  <= 1'b0;
            exp_fd <= 1'b0;
        end
    end

    logic [71:0] seen [$];
    logic        seen_fd [$];
    bit          toggle_mode;
    logic        prev_ov;

    function automatic logic [71:0] pk(input logic [7:0] w00, w01, w02, w10, w11, w12, w20, w21, w22);
        return {w22, w21, w20, w12, w11, w10, w02, w01, w00};
    endfunction

    task automatic expect_eq(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: compare outputs of the previous edge, then drive the next inputs
    task automatic cyc(input logic v, input logic [7:0] p);
        @(negedge clock);
        expect_eq("ovalid", 72'(bus.ovalid), 72'(exp_v));
        expect_eq("frame_done", 72'(bus.frame_done), 72'(exp_fd));
        expect_eq("win_out", bus.win_out, exp_win);
        if (toggle_mode) expect_eq("no_back_to_back", 72'(prev_ov && bus.ovalid), 72'(0));
        prev_ov = bus.ovalid;
        if (bus.ovalid) begin
            seen.push_back(bus.win_out);
            seen_fd.push_back(bus.frame_done);
        end
        bus.ivalid   = v;
        bus.pixel_in = p;
    endtask

    task automatic frame(input logic [7:0] off, input bit tog);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cyc(1'b1, 8'(off + r*16 + c));
                if (tog) cyc(1'b0, 8'hEE);
            end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic clear_seen();
        seen.delete();
        seen_fd.delete();
    endtask

    logic [71:0] w_first, w_last, w_left, w_f2, w_f2_last;
    int          fd_cnt;
    bit          mixed;

    initial begin
        n_assert = 0; n_fail = 0;
        toggle_mode = 0; prev_ov = 0;
        reset = 1'b1;
        bus.ivalid = 1'b0;
        bus.pixel_in = '0;
        w_first   = pk(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22);
        w_last    = pk(8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34);
        w_left    = pk(8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32);
        w_f2      = pk(8'h80, 8'h81, 8'h82, 8'h90, 8'h91, 8'h92, 8'hA0, 8'hA1, 8'hA2);
        w_f2_last = pk(8'h92, 8'h93, 8'h94, 8'hA2, 8'hA3, 8'hA4, 8'hB2, 8'hB3, 8'hB4);

        // Reset held while pixels are offered
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h30 + i));
        cyc(1'b0, 8'h00);
        expect_eq("reset_ovalid", 72'(bus.ovalid), 72'(0));
        expect_eq("reset_frame_done", 72'(bus.frame_done), 72'(0));
        expect_eq("reset_win", bus.win_out, 72'(0));
        reset = 1'b0;
        clear_seen();

        // Continuous frame
        frame(8'h00, 1'b0);
        idle(3);
        expect_eq("cont_count", 72'(seen.size()), 72'(6));
        if (seen.size() == 6) begin
            expect_eq("cont_first", seen[0], w_first);
            expect_eq("cont_left_edge", seen[3], w_left);
            expect_eq("cont_last", seen[5], w_last);
            expect_eq("cont_last_fd", 72'(seen_fd[5]), 72'(1));
            fd_cnt = 0;
            foreach (seen_fd[i]) fd_cnt += int'(seen_fd[i]);
            expect_eq("cont_fd_count", 72'(fd_cnt), 72'(1));
        end

        // Same frame with ivalid toggling
        clear_seen();
        toggle_mode = 1;
        frame(8'h00, 1'b1);
        idle(3);
        toggle_mode = 0;
        expect_eq("tog_count", 72'(seen.size()), 72'(6));
        if (seen.size() == 6) begin
            expect_eq("tog_first", seen[0], w_first);
            expect_eq("tog_left_edge", seen[3], w_left);
            expect_eq("tog_last", seen[5], w_last);
        end

        // Back-to-back frames, second offset by 0x80
        clear_seen();
        frame(8'h00, 1'b0);
        frame(8'h80, 1'b0);
        idle(3);
        expect_eq("b2b_count", 72'(seen.size()), 72'(12));
        if (seen.size() == 12) begin
            expect_eq("b2b_f2_first", seen[6], w_f2);
            expect_eq("b2b_f2_last", seen[11], w_f2_last);
            mixed = 0;
            for (int i = 0; i < 12; i++)
                for (int b = 0; b < 9; b++)
                    if ((seen[i][b*8+7] == 1'b1) != (i >= 6)) mixed = 1;
            expect_eq("b2b_no_mix", 72'(mixed), 72'(0));
        end

        // Partial frame up to pixel (2,3), then reset and a clean frame
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c <= 3) cyc(1'b1, 8'(8'h40 + r*16 + c));
        reset = 1'b1;
        cyc(1'b1, 8'h77);
        cyc(1'b1, 8'h78);
        cyc(1'b0, 8'h00);
        reset = 1'b0;
        clear_seen();
        frame(8'h00, 1'b0);
        idle(3);
        expect_eq("rst_count", 72'(seen.size()), 72'(6));
        if (seen.size() == 6) begin
            expect_eq("rst_first", seen[0], w_first);
            expect_eq("rst_last", seen[5], w_last);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
